// File: rtl/alu_input_sequencer_pkg.sv
// Shared definitions for the ALU input sequencer: FSM state encoding,
// the default debounce length and the opcode width.
package alu_input_sequencer_pkg;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_OP    = 2'd2,
        S_ISSUE = 2'd3
    } state_e;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 20000;
    localparam int unsigned OP_W                    = 4;

endpackage

// File: rtl/debouncer.sv
// Button conditioning: 2-flop synchronizer, stable-level debouncer and a
// one-cycle press pulse on each debounced 0->1 transition.
module debouncer
    import alu_input_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only advances while the synchronized input disagrees with
    // the accepted level; any agreement drops it back to zero.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Collects operand A, operand B and an opcode from a switch bus on debounced
// enter presses, then offers the operation to the ALU until it is accepted.
module alu_input_sequencer
    import alu_input_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned DATA_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              btn_enter,
    input  logic              btn_clear,
    input  logic              alu_ready,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [OP_W-1:0]   op,
    output logic              start,
    output logic [1:0]        stage
);

    logic enter_pulse, clear_pulse;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_enter),
        .press_o (enter_pulse)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_clear),
        .press_o (clear_pulse)
    );

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              start_q, start_d;

    // Handshake: start is valid, alu_ready is ready; the operation transfers
    // on any cycle where both are high, and start never drops before that.
    // Clear takes priority over enter and also ends a pending issue.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (clear_pulse) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else begin
            case (state_q)
                S_A: if (enter_pulse) begin
                    a_d     = data;
                    state_d = S_B;
                end
                S_B: if (enter_pulse) begin
                    b_d     = data;
                    state_d = S_OP;
                end
                S_OP: if (enter_pulse) begin
                    op_d    = data[DATA_W-1 -: OP_W];
                    state_d = S_ISSUE;
                end
                S_ISSUE: if (start_q && alu_ready) begin
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end
        start_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            start_q <= start_d;
        end
    end

    assign operand_a = a_q;
    assign operand_b = b_q;
    assign op        = op_q;
    assign start     = start_q;
    assign stage     = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer: a behavioural model predicts every output
// each cycle, with directed scenarios pinned by hand-computed literals.
module tb_alu_input_sequencer;

    localparam int N = 4;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  data = '0;
    logic          btn_enter = 1'b0;
    logic          btn_clear = 1'b0;
    logic          alu_ready = 1'b0;
    logic [W-1:0]  operand_a, operand_b;
    logic [3:0]    op;
    logic          start;
    logic [1:0]    stage;

    alu_input_sequencer #(.DEBOUNCE_CYCLES(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (data),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .alu_ready (alu_ready),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .op        (op),
        .start     (start),
        .stage     (stage)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int start_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A button level is accepted once the last N synchronized samples (raw
    // input seen two clocks late) all disagree with the accepted level.
    logic [1:0]   m_stage;
    logic [W-1:0] m_a, m_b;
    logic [3:0]   m_op;
    logic [1:0]   m_raw   [2];
    logic [N-1:0] m_seen  [2];
    logic         m_level [2];
    logic         m_pulse [2];
    logic         m_now   [2];
    logic         m_sample;

    task automatic model_reset();
        m_stage = 2'd0;
        m_a = '0;
        m_b = '0;
        m_op = '0;
        for (int b = 0; b < 2; b++) begin
            m_raw[b] = '0;
            m_seen[b] = '0;
            m_level[b] = 1'b0;
            m_pulse[b] = 1'b0;
        end
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            if (m_pulse[1]) begin
                m_stage = 2'd0;
                m_a = '0;
                m_b = '0;
                m_op = '0;
            end else begin
                case (m_stage)
                    2'd0: if (m_pulse[0]) begin m_a = data; m_stage = 2'd1; end
                    2'd1: if (m_pulse[0]) begin m_b = data; m_stage = 2'd2; end
                    2'd2: if (m_pulse[0]) begin m_op = data[31:28]; m_stage = 2'd3; end
                    default: if (alu_ready) m_stage = 2'd0;
                endcase
            end
            m_now[0] = btn_enter;
            m_now[1] = btn_clear;
            for (int b = 0; b < 2; b++) begin
                m_sample = m_raw[b][1];
                m_raw[b] = {m_raw[b][0], m_now[b]};
                m_seen[b] = {m_seen[b][N-2:0], m_sample};
                m_pulse[b] = 1'b0;
                if (m_seen[b] == {N{~m_level[b]}}) begin
                    m_level[b] = ~m_level[b];
                    m_pulse[b] = m_level[b];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("stage", 32'(stage), 32'(m_stage));
        check("start", 32'(start), 32'(m_stage == 2'd3));
        check("operand_a", operand_a, m_a);
        check("operand_b", operand_b, m_b);
        check("op", 32'(op), 32'(m_op));
        if (start === 1'b1) start_total++;
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input logic e, input logic c, input logic [W-1:0] d,
                         input int hold, input int rel);
        data = d;
        btn_enter = e;
        btn_clear = c;
        cyc(hold);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        cyc(rel);
    endtask

    int st0;

    initial begin
        #3 rst_n = 1'b0;
        cyc(3);
        check("reset_stage", 32'(stage), 32'd0);
        check("reset_start", 32'(start), 32'd0);
        check("reset_a", operand_a, 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // Bounce 1,0,1 then hold for 100 cycles: one pulse, one advance.
        data = 32'h5;
        alu_ready = 1'b1;
        btn_enter = 1'b1; cyc(2);
        btn_enter = 1'b0; cyc(2);
        btn_enter = 1'b1;
        cyc(6);
        check("bounce_before_latch", 32'(stage), 32'd0);
        cyc(1);
        check("bounce_latch_stage", 32'(stage), 32'd1);
        check("bounce_latch_a", operand_a, 32'd5);
        cyc(93);
        check("hold_no_repeat", 32'(stage), 32'd1);
        btn_enter = 1'b0;
        cyc(10);

        // Full entry with a ready ALU.
        press(1'b1, 1'b0, 32'h3, 8, 8);
        check("entry_b_stage", 32'(stage), 32'd2);
        check("entry_b", operand_b, 32'd3);
        st0 = start_total;
        press(1'b1, 1'b0, 32'h2ABC_DEF0, 8, 8);
        check("entry_done_stage", 32'(stage), 32'd0);
        check("entry_op", 32'(op), 32'd2);
        check("entry_a_held", operand_a, 32'd5);
        check("entry_b_held", operand_b, 32'd3);
        check("entry_start_cycles", 32'(start_total - st0), 32'd1);

        // Backpressure.
        alu_ready = 1'b0;
        press(1'b1, 1'b0, 32'h7, 8, 8);
        press(1'b1, 1'b0, 32'h9, 8, 8);
        press(1'b1, 1'b0, 32'h5000_0000, 8, 8);
        cyc(10);
        check("bp_start", 32'(start), 32'd1);
        check("bp_stage", 32'(stage), 32'd3);
        alu_ready = 1'b1;
        cyc(1);
        check("bp_release_start", 32'(start), 32'd0);
        check("bp_release_stage", 32'(stage), 32'd0);
        check("bp_op_held", 32'(op), 32'd5);

        // Clear in S_OP, then clear and enter together.
        alu_ready = 1'b0;
        press(1'b1, 1'b0, 32'h5, 8, 8);
        press(1'b1, 1'b0, 32'h3, 8, 8);
        check("clr_pre_stage", 32'(stage), 32'd2);
        press(1'b0, 1'b1, 32'hFFFF_FFFF, 8, 8);
        check("clr_stage", 32'(stage), 32'd0);
        check("clr_a", operand_a, 32'd0);
        check("clr_b", operand_b, 32'd0);
        check("clr_op", 32'(op), 32'd0);
        press(1'b1, 1'b1, 32'h11, 8, 8);
        check("clr_win_stage", 32'(stage), 32'd0);
        check("clr_win_a", operand_a, 32'd0);

        // Reset while issuing, with enter held through release.
        press(1'b1, 1'b0, 32'h1, 8, 8);
        press(1'b1, 1'b0, 32'h2, 8, 8);
        press(1'b1, 1'b0, 32'h3000_0000, 8, 8);
        check("rst_pre_stage", 32'(stage), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_start", 32'(start), 32'd0);
        check("rst_async_stage", 32'(stage), 32'd0);
        data = 32'h42;
        btn_enter = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        cyc(20);
        btn_enter = 1'b0;
        cyc(10);
        check("rst_held_stage", 32'(stage), 32'd1);
        check("rst_held_a", operand_a, 32'h42);

        // Randomized traffic, with occasional resets.
        for (int i = 0; i < 400; i++) begin
            data = $urandom;
            alu_ready = ($urandom_range(0, 3) != 0);
            btn_enter = 1'($urandom_range(0, 1));
            btn_clear = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 40) == 0) begin
                #2 rst_n = 1'b0;
                cyc($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            cyc($urandom_range(1, 10));
        end
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        cyc(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
